// File: rtl/fp_add_align.sv
// Single-precision add/subtract front end: unpack, magnitude order, align
// with sticky, and significand add/subtract. Produces an unnormalized
// {sign, exponent, 31-bit magnitude} word with a fixed 3-cycle latency.
module fp_add_align #(
  parameter bit FLUSH_DENORM = 1'b1
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iValid,
  input  logic [31:0] iA,
  input  logic [31:0] iB,
  input  logic        iSub,
  output logic        oValid,
  output logic [39:0] oSum
);

  // Input capture
  logic        v0;
  logic [31:0] a0;
  logic [31:0] b0;
  logic        sub0;

  // Stage 1 (unpack/compare) combinational results
  logic [7:0]  ea;
  logic [7:0]  eb;
  logic [30:0] ma;
  logic [30:0] mb;
  logic        sign_b;
  logic        a_ge;
  logic [7:0]  diff;
  logic [7:0]  c1_exp_l;
  logic [30:0] c1_ml;
  logic [30:0] c1_ms;
  logic        c1_sign_l;
  logic [4:0]  c1_d;
  logic        c1_spec;
  logic        c1_spec_sign;

  // Stage 1 registers
  logic        v1;
  logic        spec1;
  logic        spec_sign1;
  logic        sub1;
  logic        sign_l1;
  logic [7:0]  exp_l1;
  logic [30:0] ml1;
  logic [30:0] ms1;
  logic [4:0]  d1;

  // Stage 2 (align) signals and registers
  logic [30:0] shifted;
  logic [30:0] lost_mask;
  logic [30:0] ms_al;
  logic        v2;
  logic        spec2;
  logic        spec_sign2;
  logic        sub2;
  logic        sign_l2;
  logic [7:0]  exp_l2;
  logic [30:0] ml2;
  logic [30:0] ms2;

  // Stage 3 (add) signals
  logic [30:0] mag;
  logic [39:0] sum_next;

  // Capture the operand pair every cycle; only v0 gives it meaning
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      v0   <= 1'b0;
      a0   <= '0;
      b0   <= '0;
      sub0 <= 1'b0;
    end else begin
      v0   <= iValid;
      a0   <= iA;
      b0   <= iB;
      sub0 <= iSub;
    end
  end

  // Unpack both operands, pick the larger magnitude and the exponent gap
  always_comb begin
    ea = a0[30:23];
    ma = {2'b01, a0[22:0], 6'b0};
    if (a0[30:23] == 8'd0) begin
      ea = FLUSH_DENORM ? 8'd0 : 8'd1;
      ma = FLUSH_DENORM ? '0 : {2'b00, a0[22:0], 6'b0};
    end
    eb = b0[30:23];
    mb = {2'b01, b0[22:0], 6'b0};
    if (b0[30:23] == 8'd0) begin
      eb = FLUSH_DENORM ? 8'd0 : 8'd1;
      mb = FLUSH_DENORM ? '0 : {2'b00, b0[22:0], 6'b0};
    end
    sign_b = b0[31] ^ sub0;
    // {exp, M} orders magnitudes; equal keys keep A as the larger operand
    a_ge = {ea, ma} >= {eb, mb};
    if (a_ge) begin
      c1_exp_l  = ea;
      c1_ml     = ma;
      c1_ms     = mb;
      c1_sign_l = a0[31];
      diff      = ea - eb;
    end else begin
      c1_exp_l  = eb;
      c1_ml     = mb;
      c1_ms     = ma;
      c1_sign_l = sign_b;
      diff      = eb - ea;
    end
    c1_d         = (diff > 8'd31) ? 5'd31 : diff[4:0];
    c1_spec      = (&a0[30:23]) | (&b0[30:23]);
    c1_spec_sign = (&a0[30:23]) ? a0[31] : sign_b;
  end

  // Stage 1 register: ordered operands and shift distance
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      v1         <= 1'b0;
      spec1      <= 1'b0;
      spec_sign1 <= 1'b0;
      sub1       <= 1'b0;
      sign_l1    <= 1'b0;
      exp_l1     <= '0;
      ml1        <= '0;
      ms1        <= '0;
      d1         <= '0;
    end else begin
      v1         <= v0;
      spec1      <= c1_spec;
      spec_sign1 <= c1_spec_sign;
      sub1       <= a0[31] ^ sign_b;
      sign_l1    <= c1_sign_l;
      exp_l1     <= c1_exp_l;
      ml1        <= c1_ml;
      ms1        <= c1_ms;
      d1         <= c1_d;
    end
  end

  // Right-shift the smaller significand, folding lost bits into the sticky
  always_comb begin
    shifted   = ms1 >> d1;
    lost_mask = (31'd1 << d1) - 31'd1;
    if (d1 == 5'd31) begin
      ms_al = {30'b0, |ms1};
    end else begin
      ms_al = {shifted[30:1], shifted[0] | (|(ms1 & lost_mask))};
    end
  end

  // Stage 2 register: aligned operands
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      v2         <= 1'b0;
      spec2      <= 1'b0;
      spec_sign2 <= 1'b0;
      sub2       <= 1'b0;
      sign_l2    <= 1'b0;
      exp_l2     <= '0;
      ml2        <= '0;
      ms2        <= '0;
    end else begin
      v2         <= v1;
      spec2      <= spec1;
      spec_sign2 <= spec_sign1;
      sub2       <= sub1;
      sign_l2    <= sign_l1;
      exp_l2     <= exp_l1;
      ml2        <= ml1;
      ms2        <= ms_al;
    end
  end

  // Add or subtract significands and form the result word
  always_comb begin
    mag = sub2 ? (ml2 - ms2) : (ml2 + ms2);
    if (spec2) begin
      sum_next = {spec_sign2, 8'hFF, 31'h0};
    end else if (mag == 31'h0) begin
      sum_next = '0;
    end else begin
      sum_next = {sign_l2, exp_l2, mag};
    end
  end

  // Output register
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oValid <= 1'b0;
      oSum   <= '0;
    end else begin
      oValid <= v2;
      oSum   <= sum_next;
    end
  end

endmodule

// File: doc/fp_add_align.md
# fp_add_align

Pipelined single-precision floating-point add/subtract front end. It unpacks two IEEE-754 binary32 operands, orders them by magnitude, aligns the smaller one with guard/sticky extension, and adds or subtracts the significands. The result is the 40-bit unnormalized word {sign, exponent, 31-bit magnitude} that the downstream normalizer/rounder consumes directly. Throughput is one operation per clock.

## Interface
- FLUSH_DENORM, default 1: controls subnormal inputs (exp field 0).
  - 1: operand treated as zero.
  - 0: hidden bit 0, effective exponent 1.
- iCLK  in  1  clock; all state updates on the rising edge.
- iRST  in  1  asynchronous, active-high reset.
- iValid  in  1  operand pair present this cycle.
- iA  in  32  binary32 operand A.
- iB  in  32  binary32 operand B.
- iSub  in  1  1 computes A−B (B sign inverted at unpack); 0 computes A+B.
- oValid  out  1  oSum holds a result this cycle.
- oSum  out  40  unnormalized result word:
  - [39] sign.
  - [38:31] biased exponent.
  - [30:0] magnitude M.

## Operation
- Magnitude format M[30:0]:
  - [30] addition carry.
  - [29] hidden one.
  - [28:6] fraction.
  - [5:1] guard bits.
  - [0] sticky.
- Value = M × 2^(E−127−29). A normal operand unpacks to M = {1'b0, 1'b1, frac, 6'b0}.
- Stage 1 (unpack/compare):
  - Unpack both operands and apply FLUSH_DENORM.
  - Effective subtract = signA XOR signB' (B' = B with sign flipped when iSub = 1).
  - Larger operand L = the one with the greater {exp, frac}. On a tie, L = A.
  - d = expL − expS, saturated to 31.
- Stage 2 (align):
  - MS = S.M >> d.
  - Bit 0 of MS is ORed with the OR of every bit shifted out (sticky).
  - d ≥ 31 gives MS = 31'h1 if S is nonzero, else 0.
- Stage 3 (add):
  - Effective add: M = L.M + MS.
  - Effective subtract: M = L.M − MS.
  - Sign = sign of L; E = expL. L ≥ S, so subtraction never underflows.
- Exact zero result (M = 0): oSum = 40'h0 (+0, exponent 0), including −0 + −0.
- Special operands (exp field 255 on either input):
  - oSum = {sign of the special operand, 8'hFF, 31'h0}.
  - If both are special, use A's sign.
  - NaN/inf are not distinguished and there is no invalid flag; the normalizer's infinity path handles 8'hFF.
- No normalization, rounding or exponent adjust is done here. These belong to the downstream stage.

## Timing
- Latency: exactly 3 cycles. An input sampled at edge n (iValid = 1) appears with oValid = 1 after edge n+3.
- Valid-only pipeline: no backpressure. A new operation is accepted every cycle. oValid is the iValid delayed by 3 edges.
- Stage registers capture unconditionally. Data under oValid = 0 is don't-care, but it must not be X after reset.
- Reset (iRST = 1, takes effect immediately, asynchronous):
  - All valid bits → 0; oValid = 0.
  - oSum = 40'h0; all stage data registers → 0.
- Reset mid-stream: every in-flight operation is discarded and never emerges. The first input sampled after iRST deasserts emerges 3 cycles later.
- iA/iB/iSub are sampled only on edges where iValid = 1 is meaningful. Values are don't-care when iValid = 0.

## Test plan
- **1.0 + 1.0**: iA = 32'h3F800000, iB = 32'h3F800000, iSub = 0, single iValid pulse → exactly 3 cycles later oValid = 1 for one cycle, oSum = 40'h3FC0000000.
- **1.0 − 1.0 and −0 + −0**: iA = iB = 32'h3F800000, iSub = 1 → oSum = 40'h0000000000. Then iA = iB = 32'h80000000, iSub = 0 → oSum = 40'h0.
- **Sticky at maximum shift**: iA = 32'h3F800000, iB = 32'h30800000 (2^−30), iSub = 0 → oSum = 40'h3FA0000001.
- **Operand swap and subtract**: iA = 32'h40400000 (3.0), iB = 32'h40A00000 (5.0), iSub = 1 → oSum = 40'hC090000000 (sign 1, E = 0x81, M = 0x10000000, value −2).
- **Special operand**: iA = 32'h7F800000, iB = 32'h3F800000, iSub = 0 → oSum = 40'h7F80000000. Then iA = 32'hFF800000 → oSum = 40'hFF80000000.
- **Streaming and reset**:
  - Apply 8 back-to-back valid pairs (1.0 + k·1.0, k = 0..7) → 8 consecutive oValid cycles in order, starting at cycle 3.
  - Repeat the stream, asserting iRST asynchronously between edges 2 and 3 → oValid and oSum go to 0 immediately, and no pre-reset result appears afterward.
  - Release reset and issue one 1.0 + 1.0 → oSum = 40'h3FC0000000 exactly 3 cycles later.
